// File: rtl/gray_to_bin_pkg.sv
// Shared types and helpers for the iterative Gray-to-binary decoder.
// Holds the FSM state enum, the default width and an index-width helper.
package gray_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Output step checker: flags any decoded word that is not previous+1.
// Ports: clk, rst_n, fire (output handshake), b (decoded word), step_err.
module gray_step_chk
  import gray_to_bin_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fire,
  input  logic [WIDTH-1:0] b,
  output logic             step_err
);

  logic [WIDTH-1:0] last_b;
  logic             have_last;

  // Modular +1 compare, so all-ones -> 0 counts as a legal step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err  <= 1'b0;
      last_b    <= '0;
      have_last <= 1'b0;
    end else begin
      step_err <= fire && have_last
                  && (b != last_b + WIDTH'(1));
      if (fire) begin
        last_b    <= b;
        have_last <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_to_bin_seq.sv
// Iterative Gray-to-binary decoder, one bit per clock MSB first.
// Ports: clk, rst_n, in_valid/in_ready/g_in, out_valid/out_ready/b_out,
// busy; step_err only when GRAY_TO_BIN_STEP_CHK_EN is defined.
module gray_to_bin_seq
  import gray_to_bin_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             busy
`ifdef GRAY_TO_BIN_STEP_CHK_EN
  ,
  output logic             step_err
`endif
);

  localparam int IW = clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] b_upd;
  logic [WIDTH-1:0] b_hold;
  logic [IW-1:0]    idx;
  logic             prev;
  logic             bit_nx;
  logic             fire_out;

  assign bit_nx   = g_reg[idx] ^ prev;
  assign fire_out = out_valid && out_ready;
  assign b_out    = b_hold;

  always_comb begin
    b_upd      = b_reg;
    b_upd[idx] = bit_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (idx == '0) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // b_hold keeps the last full result, so b_out never shows a
  // partially decoded word while b_reg is being rebuilt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      g_reg  <= '0;
      b_reg  <= '0;
      b_hold <= '0;
      idx    <= '0;
      prev   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        g_reg <= g_in;
        b_reg <= '0;
        prev  <= 1'b0;
        idx   <= IW'(WIDTH - 1);
      end else if (state == BUSY) begin
        b_reg <= b_upd;
        prev  <= bit_nx;
        if (idx == '0) begin
          b_hold <= b_upd;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

`ifdef GRAY_TO_BIN_STEP_CHK_EN
  gray_step_chk #(
    .WIDTH(WIDTH)
  ) u_step_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .fire     (fire_out),
    .b        (b_reg),
    .step_err (step_err)
  );
`else
  logic unused_fire;
  assign unused_fire = fire_out;
`endif

endmodule
